// File: rtl/rex_game_if.sv
// rtl/rex_game_if.sv - control/status bundle between the Rex Runner sequencer and its user
//
// Signals:
//   start_i        start button level (user -> sequencer)
//   jump_i         jump button level (user -> sequencer)
//   game_state     2'b00 IDLE, 2'b01 RUN, 2'b10 OVER
//   rex_down       rex height above ground, px
//   obstacle_left  obstacle left-edge x, px
//   score          obstacles cleared, wraps modulo 2^16
//   frame_o        one-cycle pulse per game frame
// Modports: master drives the buttons and observes the game outputs; slave is the sequencer.

interface rex_game_if;
    logic        start_i;
    logic        jump_i;
    logic [1:0]  game_state;
    logic [15:0] rex_down;
    logic [15:0] obstacle_left;
    logic [15:0] score;
    logic        frame_o;

    modport master (
        output start_i,
        output jump_i,
        input  game_state,
        input  rex_down,
        input  obstacle_left,
        input  score,
        input  frame_o
    );

    modport slave (
        input  start_i,
        input  jump_i,
        output game_state,
        output rex_down,
        output obstacle_left,
        output score,
        output frame_o
    );
endinterface

// File: rtl/rex_game_ctrl.sv
// rtl/rex_game_ctrl.sv - Rex Runner game-state sequencer: frame tick, FSM, jump, obstacle, score
//
// Ports:
//   clk      system clock (120 kHz nominal), only clock
//   rst      synchronous, active-high reset
//   game_io  rex_game_if.slave: start_i/jump_i in; game_state, rex_down, obstacle_left,
//            score, frame_o out (all outputs registered)

module rex_game_ctrl #(
    parameter int FRAME_DIV = 4000,
    parameter int SCREEN_W  = 128,
    parameter int SPEED     = 2,
    parameter int JUMP_V    = 8,
    parameter int REX_X     = 8,
    parameter int REX_W     = 16,
    parameter int OBST_H    = 16
) (
    input  logic       clk,
    input  logic       rst,
    rex_game_if.slave  game_io
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic               frame_q;
    logic               start_q;
    logic [15:0]        rex_down_q;
    logic [15:0]        obstacle_left_q;
    logic [15:0]        score_q;
    logic signed [7:0]  vel_q;
    logic               airborne_q;

    logic               tick_d;
    logic               start_rise_d;
    logic               collide_d;
    logic signed [16:0] h_d;

    always_comb begin
        tick_d       = (div_q == DIV_W'(FRAME_DIV - 1));
        start_rise_d = game_io.start_i & ~start_q;
        collide_d    = (obstacle_left_q >= 16'(REX_X)) &&
                       (obstacle_left_q <  16'(REX_X + REX_W)) &&
                       (rex_down_q      <  16'(OBST_H));
        // Next height on the way up or down; signed so a landing overshoot is seen as <= 0.
        h_d          = $signed({1'b0, rex_down_q}) + $signed({{9{vel_q[7]}}, vel_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            div_q           <= '0;
            frame_q         <= 1'b0;
            start_q         <= 1'b0;
            rex_down_q      <= 16'd0;
            obstacle_left_q <= 16'(SCREEN_W - 1);
            score_q         <= 16'd0;
            vel_q           <= 8'sd0;
            airborne_q      <= 1'b0;
        end else begin
            // Frame divider and edge register run regardless of game state.
            div_q   <= tick_d ? '0 : div_q + 1'b1;
            frame_q <= tick_d;
            start_q <= game_io.start_i;

            case (state_q)
                ST_IDLE: begin
                    if (start_rise_d) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_d) begin
                        if (collide_d) begin
                            state_q <= ST_OVER;
                        end else begin
                            if (airborne_q) begin
                                if (h_d <= 17'sd0) begin
                                    rex_down_q <= 16'd0;
                                    vel_q      <= 8'sd0;
                                    airborne_q <= 1'b0;
                                end else begin
                                    rex_down_q <= h_d[15:0];
                                    vel_q      <= vel_q - 8'sd1;
                                end
                            end else if (game_io.jump_i) begin
                                airborne_q <= 1'b1;
                                rex_down_q <= 16'(JUMP_V);
                                vel_q      <= 8'(JUMP_V - 1);
                            end

                            // Wrap before the subtraction could go below zero.
                            if (obstacle_left_q < 16'(SPEED)) begin
                                obstacle_left_q <= 16'(SCREEN_W - 1);
                                score_q         <= score_q + 16'd1;
                            end else begin
                                obstacle_left_q <= obstacle_left_q - 16'(SPEED);
                            end
                        end
                    end
                end
                ST_OVER: begin
                    // Restart clears the playfield but leaves the divider phase untouched.
                    if (start_rise_d) begin
                        state_q         <= ST_RUN;
                        rex_down_q      <= 16'd0;
                        vel_q           <= 8'sd0;
                        airborne_q      <= 1'b0;
                        obstacle_left_q <= 16'(SCREEN_W - 1);
                        score_q         <= 16'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign game_io.game_state    = state_q;
    assign game_io.rex_down      = rex_down_q;
    assign game_io.obstacle_left = obstacle_left_q;
    assign game_io.score         = score_q;
    assign game_io.frame_o       = frame_q;

endmodule
